gb_serial_port: RTL and testbench

- Memory-mapped responder for the Game Boy serial link registers: SB at 0xFF01 and SC at 0xFF02.
- Sits on the CPU bus next to the memory map. The CPU is the initiator; this block decodes and answers its reads and writes.
- Shifts 8-bit transfers in and out on the link pins, using either the internal clock (master) or an external clock (slave).
- Drives serial_int into the interrupt lines when a transfer completes.

---
 rtl/gb_serial_port.sv | 168 ++++++++++++++++
 tb/tb_gb_serial_port.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gb_serial_port.sv
// gb_serial_port - Game Boy serial link responder (SB data, SC control).
//   Answers CPU reads/writes at SB_ADDR/SC_ADDR and shifts 8-bit transfers
//   MSB-first on the link pins, clocked either internally (master) or by an
//   external shift clock (slave). serial_int pulses once per completed transfer.
// Ports:
//   clock, reset          system clock, async active-high reset
//   cpu_addr/wren/data_in CPU bus access, writes sampled on the clock edge
//   data_out, sel         combinational read data and address match
//   serial_int            one-cycle completion pulse
//   sout, sin             serial data out / in (sin is asynchronous)
//   sclk_out, sclk_oe     internal shift clock and its output enable
//   sclk_in               external shift clock (asynchronous)
//
// state    | meaning
// IDLE     | no transfer; SB writable, SC[7]=0
// INT_LOW  | internal clock, low half-period (sout holds current bit)
// INT_HIGH | internal clock, high half-period (bit just sampled)
// EXT      | external clock; shift on synchronised sclk_in edges
module gb_serial_port #(
  parameter int unsigned HALF_PERIOD = 256,
  parameter logic [15:0] SB_ADDR     = 16'hFF01,
  parameter logic [15:0] SC_ADDR     = 16'hFF02
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_wren,
  input  logic [7:0]  cpu_data_in,
  output logic [7:0]  data_out,
  output logic        sel,
  output logic        serial_int,
  output logic        sout,
  input  logic        sin,
  output logic        sclk_out,
  output logic        sclk_oe,
  input  logic        sclk_in
);

  localparam int unsigned   PW         = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [PW-1:0] PHASE_LOAD = PW'(HALF_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, INT_LOW, INT_HIGH, EXT} state_t;

  state_t        state;
  logic [7:0]    sb;
  logic          sc_busy;
  logic          sc_clk;
  logic [3:0]    cnt;
  logic [PW-1:0] phase;
  logic [1:0]    sin_q;
  logic [2:0]    sclk_q;

  logic sin_s, sclk_rise, sclk_fall, wr_sb, wr_sc, phase_tc;

  assign sin_s     = sin_q[1];
  // sclk_q[1] is the synchronised clock, sclk_q[2] its previous value.
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign wr_sb     = cpu_wren && (cpu_addr == SB_ADDR);
  assign wr_sc     = cpu_wren && (cpu_addr == SC_ADDR);
  // Phase timer counts down from HALF_PERIOD-1; zero ends the half-period.
  assign phase_tc  = (phase == '0);

  assign sel     = (cpu_addr == SB_ADDR) || (cpu_addr == SC_ADDR);
  assign sclk_oe = sc_clk;

  always_comb begin
    data_out = 8'hFF;
    if (cpu_addr == SB_ADDR)      data_out = sb;
    else if (cpu_addr == SC_ADDR) data_out = {sc_busy, 6'b111111, sc_clk};
  end

  // Idle-high reset values keep the edge detector from seeing a false edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sin_q  <= 2'b11;
      sclk_q <= 3'b111;
    end else begin
      sin_q  <= {sin_q[0], sin};
      sclk_q <= {sclk_q[1:0], sclk_in};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sb         <= 8'h00;
      sc_busy    <= 1'b0;
      sc_clk     <= 1'b0;
      cnt        <= 4'd0;
      phase      <= '0;
      sout       <= 1'b1;
      sclk_out   <= 1'b1;
      serial_int <= 1'b0;
    end else begin
      serial_int <= 1'b0;
      if (wr_sc) sc_clk <= cpu_data_in[0];

      if (state == IDLE) begin
        if (wr_sb) sb <= cpu_data_in;
        if (wr_sc && cpu_data_in[7]) begin
          sc_busy <= 1'b1;
          cnt     <= 4'd0;
          sout    <= sb[7];
          phase   <= PHASE_LOAD;
          if (cpu_data_in[0]) begin
            state    <= INT_LOW;
            sclk_out <= 1'b0;
          end else begin
            state <= EXT;
          end
        end
      end else if (wr_sc && !cpu_data_in[7]) begin
        // Abort: SB keeps whatever has been shifted so far.
        state    <= IDLE;
        sc_busy  <= 1'b0;
        sclk_out <= 1'b1;
        sout     <= 1'b1;
      end else begin
        unique case (state)
          INT_LOW: begin
            if (phase_tc) begin
              state    <= INT_HIGH;
              sclk_out <= 1'b1;
              sb       <= {sb[6:0], sin_s};
              cnt      <= cnt + 4'd1;
              phase    <= PHASE_LOAD;
            end else begin
              phase <= phase - 1'b1;
            end
          end
          INT_HIGH: begin
            if (phase_tc) begin
              if (cnt == 4'd8) begin
                state      <= IDLE;
                sc_busy    <= 1'b0;
                serial_int <= 1'b1;
                sout       <= 1'b1;
              end else begin
                state    <= INT_LOW;
                sclk_out <= 1'b0;
                sout     <= sb[7];
                phase    <= PHASE_LOAD;
              end
            end else begin
              phase <= phase - 1'b1;
            end
          end
          EXT: begin
            if (cnt == 4'd8) begin
              state      <= IDLE;
              sc_busy    <= 1'b0;
              serial_int <= 1'b1;
              sout       <= 1'b1;
            end else if (sclk_rise) begin
              sb  <= {sb[6:0], sin_s};
              cnt <= cnt + 4'd1;
            end else if (sclk_fall) begin
              sout <= sb[7];
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gb_serial_port.sv
// Testbench for gb_serial_port: scoreboard of expected completions (byte and
// completion cycle) filled by the stimulus, drained by a serial_int monitor.
module tb_gb_serial_port;

  localparam int          HP      = 4;
  localparam logic [15:0] SB_ADDR = 16'hFF01;
  localparam logic [15:0] SC_ADDR = 16'hFF02;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cpu_addr = SB_ADDR;
  logic        cpu_wren = 1'b0;
  logic [7:0]  cpu_data_in = 8'h00;
  logic [7:0]  data_out;
  logic        sel, serial_int, sout, sclk_out, sclk_oe;
  logic        sin;
  logic        sin_drv = 1'b1;
  logic        loop_en = 1'b0;
  logic        sclk_in = 1'b1;

  assign sin = loop_en ? sout : sin_drv;

  gb_serial_port #(.HALF_PERIOD(HP), .SB_ADDR(SB_ADDR), .SC_ADDR(SC_ADDR)) dut (
    .clock(clock), .reset(reset), .cpu_addr(cpu_addr), .cpu_wren(cpu_wren),
    .cpu_data_in(cpu_data_in), .data_out(data_out), .sel(sel),
    .serial_int(serial_int), .sout(sout), .sin(sin), .sclk_out(sclk_out),
    .sclk_oe(sclk_oe), .sclk_in(sclk_in)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [7:0] sb;
    int         due;
  } exp_t;
  exp_t exp_q[$];

  // Monitor: every serial_int pulse must match the oldest expected transfer.
  logic prev_int = 1'b0;
  always @(negedge clock) begin
    exp_t e;
    if (prev_int) chk("int_width", serial_int, 0);
    if (serial_int && !prev_int) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_int", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("int_time", cyc, e.due);
        if (cpu_addr == SB_ADDR) chk("sb_at_done", data_out, e.sb);
      end
    end
    prev_int = serial_int;
  end

  // Records sout at each falling edge of sclk_out.
  logic bit_log_en = 1'b0;
  logic prev_sclk = 1'b1;
  logic bit_log[$];
  always @(negedge clock) begin
    if (bit_log_en && prev_sclk && !sclk_out) bit_log.push_back(sout);
    prev_sclk = sclk_out;
  end

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, output int edge_idx);
    @(negedge clock);
    cpu_addr = a; cpu_data_in = d; cpu_wren = 1'b1;
    edge_idx = cyc + 1;
    @(negedge clock);
    cpu_wren = 1'b0; cpu_addr = SB_ADDR;
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
    @(negedge clock);
    cpu_addr = a;
    #1 d = data_out;
    cpu_addr = SB_ADDR;
  endtask

  task automatic wait_idle(input int budget);
    cpu_addr = SB_ADDR;
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clock);
    @(negedge clock);
    if (exp_q.size() != 0) begin
      chk("done_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  // Internal-clock transfer: completion 16 half-periods after the SC write edge.
  task automatic int_xfer(input logic [7:0] tx, input logic [7:0] rx_exp);
    int e;
    cpu_write(SB_ADDR, tx, e);
    cpu_write(SC_ADDR, 8'h81, e);
    exp_q.push_back('{rx_exp, e + 16 * HP});
  endtask

  // External-clock transfer. A raw rise driven at cycle c is first sampled
  // at edge c+1, synchronised at c+2, shifted at c+3, completed at c+4.
  task automatic ext_xfer(input logic [7:0] tx, input logic [7:0] rx);
    int e;
    loop_en = 1'b0;
    cpu_write(SB_ADDR, tx, e);
    cpu_write(SC_ADDR, 8'h80, e);
    chk("ext_oe", sclk_oe, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      sclk_in = 1'b0; sin_drv = rx[7-k];
      repeat ($urandom_range(4, 6)) @(negedge clock);
      chk("ext_sout", sout, tx[7-k]);
      sclk_in = 1'b1;
      if (k == 7) exp_q.push_back('{rx, cyc + 4});
      repeat ($urandom_range(4, 6)) @(negedge clock);
    end
    wait_idle(20);
  endtask

  logic [7:0] rd, tx, rx;
  int         e;
  logic       b;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_sout", sout, 1);
    chk("rst_sclk_out", sclk_out, 1);
    chk("rst_int", serial_int, 0);
    chk("rst_oe", sclk_oe, 0);
    reset = 1'b0;

    cpu_read(SC_ADDR, rd); chk("rst_sc", rd, 8'h7E);
    cpu_addr = SC_ADDR; #1 chk("sel_sc", sel, 1);
    cpu_read(SB_ADDR, rd); chk("rst_sb", rd, 8'h00);
    cpu_addr = SB_ADDR; #1 chk("sel_sb", sel, 1);
    cpu_addr = 16'hFF03; #1 chk("sel_other", sel, 0);
    chk("rd_other", data_out, 8'hFF);

    // Internal mode, sin high: 0xA5 out, 0xFF in.
    sin_drv = 1'b1; loop_en = 1'b0;
    bit_log.delete(); bit_log_en = 1'b1;
    int_xfer(8'hA5, 8'hFF);
    chk("int_oe", sclk_oe, 1);
    cpu_read(SC_ADDR, rd); chk("sc_busy", rd, 8'hFF);
    wait_idle(16 * HP + 20);
    bit_log_en = 1'b0;
    tx = 8'hA5;
    chk("bit_count", bit_log.size(), 8);
    for (int k = 0; k < 8 && k < bit_log.size(); k++) chk("tx_bit", bit_log[k], tx[7-k]);
    cpu_read(SB_ADDR, rd); chk("sb_after_a5", rd, 8'hFF);
    cpu_read(SC_ADDR, rd); chk("sc_after_a5", rd, 8'h7F);

    // Loopback keeps SB unchanged; a mid-transfer SB write is ignored.
    loop_en = 1'b1;
    int_xfer(8'h3C, 8'h3C);
    repeat (20) @(negedge clock);
    cpu_write(SB_ADDR, 8'h99, e);
    wait_idle(16 * HP + 20);
    cpu_read(SB_ADDR, rd); chk("sb_loop", rd, 8'h3C);
    loop_en = 1'b0;

    // External mode.
    ext_xfer(8'h0F, 8'hC3);
    cpu_read(SB_ADDR, rd); chk("sb_ext", rd, 8'hC3);
    // Ninth pulse after completion: no shift, no interrupt.
    @(negedge clock); sclk_in = 1'b0; sin_drv = 1'b0;
    repeat (5) @(negedge clock); sclk_in = 1'b1;
    repeat (10) @(negedge clock);
    cpu_read(SB_ADDR, rd); chk("sb_9th", rd, 8'hC3);

    // Abort after three internal bits: SB = 0xA5 shifted 3 with ones in.
    sin_drv = 1'b1;
    cpu_write(SB_ADDR, 8'hA5, e);
    cpu_write(SC_ADDR, 8'h81, e);
    for (int i = 0; i < 100 && cyc < e + 6 * HP + 1; i++) @(negedge clock);
    cpu_write(SC_ADDR, 8'h01, e);
    chk("abort_sclk", sclk_out, 1);
    cpu_read(SC_ADDR, rd); chk("abort_sc", rd, 8'h7F);
    cpu_read(SB_ADDR, rd); chk("abort_sb", rd, 8'h2F);
    repeat (64) @(negedge clock);
    cpu_write(SB_ADDR, 8'h55, e);
    cpu_read(SB_ADDR, rd); chk("sb_after_abort", rd, 8'h55);

    // Reset mid-transfer.
    int_xfer(8'h81, 8'hFF);
    repeat (10) @(negedge clock);
    reset = 1'b1;
    #1;
    exp_q.delete();
    chk("mid_rst_sout", sout, 1);
    chk("mid_rst_sclk", sclk_out, 1);
    chk("mid_rst_int", serial_int, 0);
    chk("mid_rst_oe", sclk_oe, 0);
    @(negedge clock); reset = 1'b0;
    cpu_read(SC_ADDR, rd); chk("mid_rst_sc", rd, 8'h7E);
    cpu_read(SB_ADDR, rd); chk("mid_rst_sb", rd, 8'h00);
    repeat (80) @(negedge clock);

    // Randomized transfers.
    for (int n = 0; n < 6; n++) begin
      tx = 8'($urandom());
      case ($urandom_range(0, 2))
        0: begin
          loop_en = 1'b1;
          int_xfer(tx, tx);
          wait_idle(16 * HP + 20);
          loop_en = 1'b0;
        end
        1: begin
          b = 1'($urandom());
          sin_drv = b;
          int_xfer(tx, {8{b}});
          wait_idle(16 * HP + 20);
        end
        default: begin
          rx = 8'($urandom());
          ext_xfer(tx, rx);
          cpu_read(SB_ADDR, rd); chk("sb_ext_rand", rd, rx);
        end
      endcase
    end

    repeat (5) @(negedge clock);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
